// File: rtl/m6502_int_pkg.sv
// Shared constants and types for the M6502-style multi-channel interrupt controller.
package m6502_int_pkg;

    localparam logic [7:0] VEC_RES  = 8'hFC;
    localparam logic [7:0] VEC_NMI  = 8'hFA;
    localparam logic [7:0] VEC_IRQ0 = 8'hFE;

    localparam int SRC_RES      = 0;
    localparam int SRC_NMI      = 1;
    localparam int SRC_IRQ_BASE = 2;

    typedef enum logic {IDLE, SERVICE} state_e;

    // Channel 0 keeps the classic IRQ vector; higher channels step down by two bytes.
    function automatic logic [7:0] irq_vec(input logic [7:0] base, input int k);
        if (k == 0) return VEC_IRQ0;
        return base - 8'(2 * (k - 1));
    endfunction

endpackage

// File: rtl/nmi_edge_detector.sv
// Falling-edge latch for NMI; a fresh edge beats a same-cycle clear.
module nmi_edge_detector (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic nmi_n,
    input  logic clr,
    output logic pending
);

    logic prev_q, prev_d;
    logic pending_q, pending_d;

    always_comb begin
        prev_d    = prev_q;
        pending_d = pending_q;
        if (en) begin
            prev_d    = nmi_n;
            pending_d = (prev_q & ~nmi_n) | (pending_q & ~clr);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 1'b1;
            pending_q <= 1'b0;
        end else begin
            prev_q    <= prev_d;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/multi_channel_interrupt_controller.sv
// Reset/NMI/multi-IRQ arbitration at the instruction boundary, held until vector fetch ack.
// Optional NMI hijack of an in-flight IRQ vector fetch is enabled by defining NMI_HIJACK_EN.
module multi_channel_interrupt_controller
    import m6502_int_pkg::*;
#(
    parameter int          NUM_IRQ      = 4,
    parameter logic [7:0]  IRQ_VEC_BASE = 8'hEE,
    localparam int         SRC_W        = $clog2(NUM_IRQ + 2)
) (
    input  logic               CLK_IN,
    input  logic               RES_N,
    input  logic               rdy,
    input  logic               sample_t0,
    input  logic               nmi_n,
    input  logic [NUM_IRQ-1:0] irq_n,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               i_flag,
    input  logic               vec_ack,
    output logic               int_req,
    output logic               reset_seq,
    output logic [SRC_W-1:0]   src,
    output logic [7:0]         vec_adl,
    output logic               nmi_pending
);

    state_e             state_q, state_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [7:0]         vec_q, vec_d;
    logic               reset_seq_q, reset_seq_d;
    logic               nmi_clr;
    logic [NUM_IRQ-1:0] irq_elig;
    logic               any_req;
    logic [SRC_W-1:0]   win_src;
    logic [7:0]         win_vec;

    nmi_edge_detector u_nmi (
        .clk     (CLK_IN),
        .rst_n   (RES_N),
        .en      (rdy),
        .nmi_n   (nmi_n),
        .clr     (nmi_clr),
        .pending (nmi_pending)
    );

    assign irq_elig = ~irq_n & irq_mask & {NUM_IRQ{~i_flag}};

    // Descending scan so the lowest-numbered eligible channel wins; NMI overrides all.
    always_comb begin
        any_req = 1'b0;
        win_src = SRC_W'(SRC_NMI);
        win_vec = VEC_NMI;
        for (int k = NUM_IRQ - 1; k >= 0; k--) begin
            if (irq_elig[k]) begin
                any_req = 1'b1;
                win_src = SRC_W'(SRC_IRQ_BASE + k);
                win_vec = irq_vec(IRQ_VEC_BASE, k);
            end
        end
        if (nmi_pending) begin
            any_req = 1'b1;
            win_src = SRC_W'(SRC_NMI);
            win_vec = VEC_NMI;
        end
    end

    always_comb begin
        state_d     = state_q;
        src_d       = src_q;
        vec_d       = vec_q;
        reset_seq_d = reset_seq_q;
        nmi_clr     = 1'b0;
        if (rdy) begin
            case (state_q)
                IDLE: begin
                    if (sample_t0 && any_req) begin
                        state_d = SERVICE;
                        src_d   = win_src;
                        vec_d   = win_vec;
                    end
                end
                SERVICE: begin
                    if (vec_ack) begin
                        state_d     = IDLE;
                        reset_seq_d = 1'b0;
                        nmi_clr     = !reset_seq_q && (src_q == SRC_W'(SRC_NMI));
                    end
`ifdef NMI_HIJACK_EN
                    else if (nmi_pending && !reset_seq_q &&
                             (src_q >= SRC_W'(SRC_IRQ_BASE))) begin
                        src_d = SRC_W'(SRC_NMI);
                        vec_d = VEC_NMI;
                    end
`endif
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_IN or negedge RES_N) begin
        if (!RES_N) begin
            state_q     <= SERVICE;
            src_q       <= SRC_W'(SRC_RES);
            vec_q       <= VEC_RES;
            reset_seq_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            src_q       <= src_d;
            vec_q       <= vec_d;
            reset_seq_q <= reset_seq_d;
        end
    end

    assign int_req   = (state_q == SERVICE);
    assign reset_seq = reset_seq_q;
    assign src       = src_q;
    assign vec_adl   = vec_q;

endmodule

// File: tb/tb_multi_channel_interrupt_controller.sv
// Directed vector table plus hand-written reset sequences for the interrupt controller.
module tb_multi_channel_interrupt_controller;

    logic       CLK_IN = 1'b0;
    logic       RES_N;
    logic       rdy, sample_t0, nmi_n, i_flag, vec_ack;
    logic [3:0] irq_n, irq_mask;
    logic       int_req, reset_seq, nmi_pending;
    logic [2:0] src;
    logic [7:0] vec_adl;

    int checks = 0;
    int errors = 0;

    multi_channel_interrupt_controller #(.NUM_IRQ(4), .IRQ_VEC_BASE(8'hEE)) dut (
        .CLK_IN      (CLK_IN),
        .RES_N       (RES_N),
        .rdy         (rdy),
        .sample_t0   (sample_t0),
        .nmi_n       (nmi_n),
        .irq_n       (irq_n),
        .irq_mask    (irq_mask),
        .i_flag      (i_flag),
        .vec_ack     (vec_ack),
        .int_req     (int_req),
        .reset_seq   (reset_seq),
        .src         (src),
        .vec_adl     (vec_adl),
        .nmi_pending (nmi_pending)
    );

    always #5 CLK_IN = ~CLK_IN;

    typedef struct {
        logic       rdy, t0, nmi_n;
        logic [3:0] irq_n, mask;
        logic       iflag, ack;
        logic       e_req, e_rs;
        logic [2:0] e_src;
        logic [7:0] e_vec;
        logic       e_pend;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic t0, logic nn, logic [3:0] in, logic [3:0] m,
                                logic fi, logic ack, logic er, logic [2:0] es,
                                logic [7:0] ev, logic ep);
        vec_t v;
        v.rdy = r; v.t0 = t0; v.nmi_n = nn; v.irq_n = in; v.mask = m;
        v.iflag = fi; v.ack = ack; v.e_req = er; v.e_rs = 1'b0;
        v.e_src = es; v.e_vec = ev; v.e_pend = ep;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic er, logic ers, logic [2:0] es,
                           logic [7:0] ev, logic ep);
        chk({tag, ".int_req"},     32'(int_req),     32'(er));
        chk({tag, ".reset_seq"},   32'(reset_seq),   32'(ers));
        chk({tag, ".src"},         32'(src),         32'(es));
        chk({tag, ".vec_adl"},     32'(vec_adl),     32'(ev));
        chk({tag, ".nmi_pending"}, 32'(nmi_pending), 32'(ep));
    endtask

    task automatic idle_inputs();
        rdy = 1'b1; sample_t0 = 1'b0; nmi_n = 1'b1; irq_n = 4'hF;
        irq_mask = 4'hF; i_flag = 1'b0; vec_ack = 1'b0;
    endtask

    initial begin
        // rdy t0 nmi irq_n mask if ack | req src vec pend
        tbl.push_back(mk(1,1,1,4'hF,4'hF,0,0, 0,3'd0,8'hFC,0)); // no request
        tbl.push_back(mk(1,1,1,4'hD,4'hF,0,0, 1,3'd3,8'hEE,0)); // IRQ1
        tbl.push_back(mk(1,1,1,4'hF,4'hF,0,0, 1,3'd3,8'hEE,0)); // t0 ignored in service
        tbl.push_back(mk(1,0,1,4'hF,4'hF,0,1, 0,3'd3,8'hEE,0)); // ack
        tbl.push_back(mk(1,0,1,4'hF,4'hF,0,1, 0,3'd3,8'hEE,0)); // ack in idle ignored
        tbl.push_back(mk(1,0,0,4'hC,4'hF,0,0, 0,3'd3,8'hEE,1)); // NMI edge
        tbl.push_back(mk(1,1,0,4'hC,4'hF,0,0, 1,3'd1,8'hFA,1)); // NMI beats IRQ0
        tbl.push_back(mk(1,0,1,4'hC,4'hF,0,1, 0,3'd1,8'hFA,0)); // NMI ack clears
        tbl.push_back(mk(1,1,1,4'hC,4'hF,0,0, 1,3'd2,8'hFE,0)); // IRQ0
        tbl.push_back(mk(1,0,1,4'hF,4'hF,0,1, 0,3'd2,8'hFE,0));
        tbl.push_back(mk(1,1,1,4'h0,4'hF,1,0, 0,3'd2,8'hFE,0)); // i_flag masks
        tbl.push_back(mk(1,1,1,4'h0,4'h0,0,0, 0,3'd2,8'hFE,0)); // irq_mask masks
        tbl.push_back(mk(1,0,0,4'h0,4'h0,0,0, 0,3'd2,8'hFE,1)); // NMI edge
        tbl.push_back(mk(1,1,0,4'h0,4'h0,0,0, 1,3'd1,8'hFA,1));
        tbl.push_back(mk(1,0,1,4'hF,4'hF,0,0, 1,3'd1,8'hFA,1)); // re-arm edge
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd1,8'hFA,1)); // edge with ack: stays set
        tbl.push_back(mk(1,1,0,4'hF,4'hF,0,0, 1,3'd1,8'hFA,1)); // NMI again
        tbl.push_back(mk(0,0,0,4'hF,4'hF,0,1, 1,3'd1,8'hFA,1)); // rdy low holds
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd1,8'hFA,0));
        tbl.push_back(mk(1,1,0,4'h7,4'hF,0,0, 1,3'd5,8'hEA,0)); // IRQ3
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd5,8'hEA,0));
        tbl.push_back(mk(1,1,0,4'hB,4'hF,0,0, 1,3'd4,8'hEC,0)); // IRQ2
        tbl.push_back(mk(1,0,1,4'hB,4'hF,0,0, 1,3'd4,8'hEC,0));
        tbl.push_back(mk(1,0,0,4'hB,4'hF,0,0, 1,3'd4,8'hEC,1)); // NMI edge mid-service
`ifdef NMI_HIJACK_EN
        tbl.push_back(mk(1,0,0,4'hB,4'hF,0,0, 1,3'd1,8'hFA,1)); // hijacked
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd1,8'hFA,0));
        tbl.push_back(mk(1,1,0,4'hF,4'hF,0,0, 0,3'd1,8'hFA,0));
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd1,8'hFA,0));
`else
        tbl.push_back(mk(1,0,0,4'hB,4'hF,0,0, 1,3'd4,8'hEC,1)); // frozen
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd4,8'hEC,1));
        tbl.push_back(mk(1,1,0,4'hF,4'hF,0,0, 1,3'd1,8'hFA,1)); // NMI at next T0
        tbl.push_back(mk(1,0,0,4'hF,4'hF,0,1, 0,3'd1,8'hFA,0));
`endif

        idle_inputs();
        RES_N = 1'b0;
        repeat (2) @(posedge CLK_IN);
        #1 chk_all("reset", 1, 1, 3'd0, 8'hFC, 0);
        RES_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK_IN);
            #1 chk_all($sformatf("rst_hold%0d", i), 1, 1, 3'd0, 8'hFC, 0);
        end
        vec_ack = 1'b1;
        @(posedge CLK_IN);
        #1 chk_all("rst_ack", 0, 0, 3'd0, 8'hFC, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            rdy = tbl[i].rdy; sample_t0 = tbl[i].t0; nmi_n = tbl[i].nmi_n;
            irq_n = tbl[i].irq_n; irq_mask = tbl[i].mask; i_flag = tbl[i].iflag;
            vec_ack = tbl[i].ack;
            @(posedge CLK_IN);
            #1 chk_all($sformatf("row%0d", i), tbl[i].e_req, tbl[i].e_rs,
                       tbl[i].e_src, tbl[i].e_vec, tbl[i].e_pend);
        end

        // Mid-cycle asynchronous reset must take effect without a clock edge.
        idle_inputs();
        #2 RES_N = 1'b0;
        #1 chk_all("async_rst", 1, 1, 3'd0, 8'hFC, 0);
        @(posedge CLK_IN);
        #1 RES_N = 1'b1;
        @(posedge CLK_IN);
        #1 chk_all("async_rst_hold", 1, 1, 3'd0, 8'hFC, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_channel_interrupt_controller.md
Name: multi_channel_interrupt_controller

Overview:
- Parametrised successor to the single-IRQ/NMI/reset interrupt control in the M6502 control path.
- Arbitrates reset, one edge-triggered NMI and NUM_IRQ level-triggered IRQ channels, each with a per-channel mask.
- Samples pending requests at the instruction boundary and presents the winning source and its low vector byte for the vector fetch.
- Holds the request until the sequencer acknowledges the vector fetch.

Parameters:
- NUM_IRQ, 4, number of maskable IRQ channels (1..8).
- IRQ_VEC_BASE, 8'hEE, low vector byte for IRQ channel 1. Channel k>=1 uses IRQ_VEC_BASE - 2*(k-1). Channel 0 always uses 8'hFE.

Ports:
- CLK_IN  input  1  CPU clock; all state updates on rising edge.
- RES_N  input  1  Reset, asynchronous, active-low.
- rdy  input  1  Ready; when low, sampling and ack are ignored and all state holds.
- sample_t0  input  1  Instruction-boundary strobe (T0); requests are evaluated here.
- nmi_n  input  1  Non-maskable interrupt, falling-edge sensitive, synchronous to CLK_IN.
- irq_n  input  NUM_IRQ  Level-sensitive IRQ requests, active-low.
- irq_mask  input  NUM_IRQ  Per-channel enable; 1 = channel allowed.
- i_flag  input  1  Processor I flag; 1 masks all IRQ channels.
- vec_ack  input  1  Vector fetch complete; ends service.
- int_req  output  1  Interrupt/reset sequence in progress.
- reset_seq  output  1  Current service is the reset sequence.
- src  output  SRC_W  Source code: 0 = reset, 1 = NMI, 2+k = IRQ k. SRC_W = $clog2(NUM_IRQ+2).
- vec_adl  output  8  Low vector byte: reset FC, NMI FA, IRQ as above. High byte is always FF (external).
- nmi_pending  output  1  Latched NMI edge not yet serviced.

Behaviour:
- States:
  - IDLE: no service in progress.
  - SERVICE: outputs valid and stable.
- Reset while RES_N=0, asynchronous:
  - state = SERVICE, src = 0, reset_seq = 1, int_req = 1, vec_adl = FC.
  - nmi_pending = 0; NMI edge-detector previous value = 1.
  - When RES_N rises, the block stays in SERVICE until vec_ack (qualified by rdy). It then clears reset_seq and goes to IDLE.
- NMI edge detector:
  - nmi_prev is registered each cycle.
  - nmi_prev=1 and nmi_n=0 sets nmi_pending.
  - nmi_pending clears on the acked NMI service.
  - A new edge in the same cycle as that ack wins: pending stays 1.
- IRQ channel k is eligible when irq_n[k]=0, irq_mask[k]=1 and i_flag=0. IRQs are not latched; a request released before sampling is lost.
- Transition IDLE -> SERVICE: when rdy & sample_t0 and any request is present.
  - Priority: NMI > IRQ0 > IRQ1 > ... > IRQ(NUM_IRQ-1).
  - src and vec_adl are registered.
  - int_req rises one cycle after the sampling cycle.
- Transition SERVICE -> IDLE: on rdy & vec_ack.
  - int_req falls the next cycle.
  - sample_t0 is ignored while in SERVICE.
- Outputs in IDLE: int_req = 0, src and vec_adl hold their last values.
- vec_ack in IDLE is ignored.
- Vector arithmetic is modulo 8 bits.

Optional Feature:
- Macro: NMI_HIJACK_EN.
- Defined:
  - While in SERVICE with an IRQ source, nmi_pending=1 before vec_ack switches src to 1 and vec_adl to FA the next cycle.
  - The subsequent ack clears nmi_pending. This mirrors NMI hijacking of an IRQ/BRK vector fetch.
  - Reset service is never hijacked.
- Undefined:
  - The source is frozen for the whole service.
  - A pending NMI is taken at the next sample_t0 after ack.

Decomposition:
- Package m6502_int_pkg holds:
  - Localparams for vectors: VEC_RES=8'hFC, VEC_NMI=8'hFA, VEC_IRQ0=8'hFE.
  - Source codes: SRC_RES=0, SRC_NMI=1, SRC_IRQ_BASE=2.
  - State typedef {IDLE, SERVICE}.
- One sub-module: nmi_edge_detector, containing the prev register, pending latch and clear/set precedence.

Test Plan:
- Hold RES_N=0, release, assert vec_ack 3 cycles later -> int_req=1, reset_seq=1, vec_adl=FC until ack; then int_req=0, reset_seq=0.
- irq_n=4'b1101, irq_mask=4'hF, i_flag=0, sample_t0 pulse -> next cycle int_req=1, src=3, vec_adl=EE.
- irq_n=4'b1100 with NMI falling edge, then sample_t0 -> src=1, vec_adl=FA. After ack, next sample_t0 -> src=2, vec_adl=FE.
- i_flag=1 or irq_mask=0 with all irq_n=0, sample_t0 -> int_req stays 0. Then NMI edge -> serviced.
- NMI edge in the same cycle as NMI vec_ack -> nmi_pending remains 1; the next sample_t0 services NMI again. rdy=0 during ack -> state holds.
- IRQ2 in service, NMI edge before ack:
  - NMI_HIJACK_EN defined -> vec_adl changes EC -> FA, src=1.
  - Undefined -> vec_adl stays EC, NMI is taken at the next T0.
